// File: rtl/iq_word_formatter_if.sv
// iq_word_formatter_if
//   Groups the streaming input from lvds_rx, the MCU gate, the spi_generator
//   busy flag and the formatted sample/strobe outputs of iq_word_formatter.
//   slave  : used by iq_word_formatter (consumes words, drives samples)
//   master : used by whatever drives the words and observes the samples
//
//   i_word        32  lvds_rx word {I_SYNC, I[13:1], I[0], Q_SYNC, Q[13:1], Q[0]}
//   i_word_valid   1  1-cycle strobe qualifying i_word
//   i_gate         1  stream enable; 0 discards input
//   i_spi_busy     1  OR of the I and Q spi_generator busy flags
//   o_i_data      16  formatted I sample
//   o_q_data      16  formatted Q sample
//   o_strobe       1  1-cycle data strobe to spi_generator
interface iq_word_formatter_if;
    logic [31:0] i_word;
    logic        i_word_valid;
    logic        i_gate;
    logic        i_spi_busy;
    logic [15:0] o_i_data;
    logic [15:0] o_q_data;
    logic        o_strobe;

    modport slave (
        input  i_word, i_word_valid, i_gate, i_spi_busy,
        output o_i_data, o_q_data, o_strobe
    );

    modport master (
        output i_word, i_word_valid, i_gate, i_spi_busy,
        input  o_i_data, o_q_data, o_strobe
    );
endinterface

// File: rtl/iq_word_formatter.sv
// iq_word_formatter
//   Checks the I_SYNC/Q_SYNC fields of each lvds_rx word, sign-extends the
//   13-bit I and Q values to 16 bits, optionally decimates, buffers samples in
//   a DEPTH-entry FIFO and hands them one at a time to the spi_generator pair
//   with a strobe/busy handshake. Counts framing errors and FIFO overflows.
//
//   clk, rst         single clock, synchronous active-high reset
//   bus              iq_word_formatter_if.slave (word in, samples/strobe out)
//   o_sync_err_cnt   saturating count of gated words with bad sync
//   o_overflow_cnt   saturating count of words dropped on a full FIFO
//   o_fifo_level     current FIFO occupancy
//
//   Optional macro IQ_FMT_RAW_EN: raw debug mode. Sync is still counted but
//   every gated word is queued, and the word halves are passed through as-is.
module iq_word_formatter #(
    parameter int DEPTH   = 8,
    parameter int DECIM   = 1,
    parameter int MIN_GAP = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    iq_word_formatter_if.slave       bus,
    output logic [15:0]              o_sync_err_cnt,
    output logic [15:0]              o_overflow_cnt,
    output logic [$clog2(DEPTH):0]   o_fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(MIN_GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} state_t;

    // ---------------- input stage ----------------
    logic        take, sync_ok, advance;
    logic [31:0] fmt_word;
    logic [7:0]  dec_cnt;
    logic        in_push;
    logic [31:0] in_data;

    assign take    = bus.i_word_valid && bus.i_gate;
    assign sync_ok = (bus.i_word[31:30] == 2'b10) && (bus.i_word[15:14] == 2'b01);

`ifdef IQ_FMT_RAW_EN
    // Every gated word is queued; decimation still thins the gated stream.
    assign advance  = take;
    assign fmt_word = bus.i_word;
`else
    assign advance  = take && sync_ok;
    assign fmt_word = {{3{bus.i_word[29]}}, bus.i_word[29:17],
                       {3{bus.i_word[13]}}, bus.i_word[13:1]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            in_push        <= 1'b0;
            in_data        <= '0;
            dec_cnt        <= '0;
            o_sync_err_cnt <= '0;
        end else begin
            in_push <= 1'b0;
            if (take && !sync_ok && o_sync_err_cnt != 16'hFFFF)
                o_sync_err_cnt <= o_sync_err_cnt + 16'd1;
            if (advance) begin
                in_push <= (dec_cnt == 8'd0);
                in_data <= fmt_word;
                dec_cnt <= (dec_cnt == 8'(DECIM - 1)) ? 8'd0 : dec_cnt + 8'd1;
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          pop, wr_en, full, empty;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    // A pop in the same cycle frees the slot, so a push on full is still accepted.
    assign wr_en = in_push && (!full || pop);
    assign o_fifo_level = count;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            o_overflow_cnt <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_push && !wr_en && o_overflow_cnt != 16'hFFFF)
                o_overflow_cnt <= o_overflow_cnt + 16'd1;
        end
    end

    // ---------------- output FSM ----------------
    state_t        state_q, state_d;
    logic [GW-1:0] gap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gap_q        <= '0;
            bus.o_i_data <= '0;
            bus.o_q_data <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= (state_q == S_HOLD) ? gap_q + 1'b1 : '0;
            if (pop) begin
                bus.o_i_data <= mem[rd_ptr][31:16];
                bus.o_q_data <= mem[rd_ptr][15:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        bus.o_strobe = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !bus.i_spi_busy) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.o_strobe = 1'b1;
                state_d      = S_HOLD;
            end
            S_HOLD: begin
                if (gap_q == GW'(MIN_GAP - 1))
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.i_spi_busy)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_iq_word_formatter.sv
// tb_iq_word_formatter
//   Directed bench for iq_word_formatter: DEPTH=8/DECIM=1/MIN_GAP=4 instance
//   for latency, formatting, sync errors, overflow and reset; a DECIM=4
//   instance for decimation.
module tb_iq_word_formatter;
    logic        clk;
    logic        rst;
    logic [15:0] a_err, a_ovf, b_err, b_ovf;
    logic [3:0]  a_lvl, b_lvl;
    int          cyc;
    int          total;
    int          passed;

    logic [31:0] qa_data[$];
    int          qa_cyc[$];
    logic [31:0] qb_data[$];

    iq_word_formatter_if ifa();
    iq_word_formatter_if ifb();

    iq_word_formatter #(.DEPTH(8), .DECIM(1), .MIN_GAP(4)) dut (
        .clk(clk), .rst(rst), .bus(ifa),
        .o_sync_err_cnt(a_err), .o_overflow_cnt(a_ovf), .o_fifo_level(a_lvl)
    );

    iq_word_formatter #(.DEPTH(8), .DECIM(4), .MIN_GAP(4)) dut_d (
        .clk(clk), .rst(rst), .bus(ifb),
        .o_sync_err_cnt(b_err), .o_overflow_cnt(b_ovf), .o_fifo_level(b_lvl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ifa.o_strobe) begin
            qa_data.push_back({ifa.o_i_data, ifa.o_q_data});
            qa_cyc.push_back(cyc);
        end
        if (ifb.o_strobe)
            qb_data.push_back({ifb.o_i_data, ifb.o_q_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] w);
        ifa.i_word       = w;
        ifa.i_word_valid = 1'b1;
        @(posedge clk);
        #1;
        ifa.i_word_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] w);
        ifb.i_word       = w;
        ifb.i_word_valid = 1'b1;
        @(posedge clk);
        #1;
        ifb.i_word_valid = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [12:0] i, input logic [12:0] q);
        return {2'b10, i, 1'b0, 2'b01, q, 1'b0};
    endfunction

    initial begin
        total = 0;
        passed = 0;
        cyc = 0;
        rst = 1'b1;
        ifa.i_word = '0; ifa.i_word_valid = 1'b0; ifa.i_gate = 1'b1; ifa.i_spi_busy = 1'b0;
        ifb.i_word = '0; ifb.i_word_valid = 1'b0; ifb.i_gate = 1'b1; ifb.i_spi_busy = 1'b0;

        // Reset state
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_strobe", {31'd0, ifa.o_strobe}, 32'd0);
        chk("rst_data", {ifa.o_i_data, ifa.o_q_data}, 32'd0);
        chk("rst_err", {16'd0, a_err}, 32'd0);
        chk("rst_ovf", {16'd0, a_ovf}, 32'd0);
        chk("rst_level", {28'd0, a_lvl}, 32'd0);
        tick(1);

        // I=+1, Q=+1: strobe in the third cycle after the valid cycle
        send_a(32'h8002_4002);
        @(negedge clk);
        chk("lat_c1_strobe", {31'd0, ifa.o_strobe}, 32'd0);
        tick(1);
        @(negedge clk);
        chk("lat_c2_strobe", {31'd0, ifa.o_strobe}, 32'd0);
        chk("lat_c2_level", {28'd0, a_lvl}, 32'd1);
        tick(1);
        @(negedge clk);
        chk("lat_c3_strobe", {31'd0, ifa.o_strobe}, 32'd1);
        chk("pos_one_data", {ifa.o_i_data, ifa.o_q_data}, 32'h0001_0001);
        chk("pos_one_level", {28'd0, a_lvl}, 32'd0);
        tick(12);

        // I=-1, Q=-1
        qa_data.delete(); qa_cyc.delete();
        send_a(32'hBFFE_7FFE);
        tick(12);
        chk("neg_one_count", qa_data.size(), 32'd1);
        if (qa_data.size() > 0) chk("neg_one_data", qa_data[0], 32'hFFFF_FFFF);

        // Bad I_SYNC
        qa_data.delete(); qa_cyc.delete();
        send_a(32'h4002_4002);
        @(negedge clk);
        chk("bad_err", {16'd0, a_err}, 32'd1);
        tick(6);
        chk("bad_level", {28'd0, a_lvl}, 32'd0);
        chk("bad_no_strobe", qa_data.size(), 32'd0);

        // Gate low: bad word ignored, nothing counted
        ifa.i_gate = 1'b0;
        send_a(32'h4002_4002);
        send_a(mk(13'd5, 13'd5));
        tick(6);
        ifa.i_gate = 1'b1;
        chk("gate_err", {16'd0, a_err}, 32'd1);
        chk("gate_no_strobe", qa_data.size(), 32'd0);

        // Overflow: busy held, 10 words into DEPTH=8
        ifa.i_spi_busy = 1'b1;
        for (int k = 1; k <= 10; k++)
            send_a(mk(13'(k), 13'h1000 | 13'(k)));
        tick(3);
        chk("ovf_level", {28'd0, a_lvl}, 32'd8);
        chk("ovf_count", {16'd0, a_ovf}, 32'd2);
        qa_data.delete(); qa_cyc.delete();
        ifa.i_spi_busy = 1'b0;
        tick(90);
        chk("drain_count", qa_data.size(), 32'd8);
        for (int k = 0; k < 8 && k < qa_data.size(); k++)
            chk($sformatf("drain_data%0d", k), qa_data[k],
                {16'(k + 1), 16'hF000 | 16'(k + 1)});
        for (int k = 1; k < 8 && k < qa_cyc.size(); k++)
            chk($sformatf("drain_gap%0d", k), {31'd0, (qa_cyc[k] - qa_cyc[k-1]) >= 6}, 32'd1);
        chk("drain_level", {28'd0, a_lvl}, 32'd0);

        // Decimation by 4 with a bad-sync word in the stream
        for (int k = 0; k < 12; k++) begin
            send_b(mk(13'(k), 13'(k + 32)));
            if (k == 1) send_b(32'h4002_4002);
        end
        tick(40);
        chk("dec_err", {16'd0, b_err}, 32'd1);
        chk("dec_count", qb_data.size(), 32'd3);
        for (int k = 0; k < 3 && k < qb_data.size(); k++)
            chk($sformatf("dec_data%0d", k), qb_data[k], {16'(4 * k), 16'(4 * k + 32)});

        // Reset while in HOLD with three samples queued
        ifa.i_spi_busy = 1'b1;
        for (int k = 0; k < 4; k++)
            send_a(mk(13'(k + 20), 13'(k + 20)));
        tick(3);
        chk("hold_level_pre", {28'd0, a_lvl}, 32'd4);
        ifa.i_spi_busy = 1'b0;
        tick(1);
        ifa.i_spi_busy = 1'b1;
        @(negedge clk);
        chk("hold_strobe", {31'd0, ifa.o_strobe}, 32'd1);
        tick(1);
        chk("hold_level", {28'd0, a_lvl}, 32'd3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hrst_strobe", {31'd0, ifa.o_strobe}, 32'd0);
        chk("hrst_data", {ifa.o_i_data, ifa.o_q_data}, 32'd0);
        chk("hrst_err", {16'd0, a_err}, 32'd0);
        chk("hrst_ovf", {16'd0, a_ovf}, 32'd0);
        chk("hrst_level", {28'd0, a_lvl}, 32'd0);
        rst = 1'b0;
        ifa.i_spi_busy = 1'b0;
        qa_data.delete(); qa_cyc.delete();
        tick(20);
        chk("hrst_no_strobe", qa_data.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
